demod_regs_mc: RTL

Synchronous, multi-channel successor of the demodulator control/status register bank. It holds per-channel demod mode, bitsync mode, DAC selects, false-lock loop and AM time-constant settings, and exposes live lock status and FSK deviation. New versus the single-channel bank: sticky lock-loss events (write-1-to-clear), a maskable interrupt, and a saturating demod-lock-loss counter per channel. It sits between the processor bus interface and NUM_CH demod channels.

---
 rtl/demod_regs_pkg.sv | 50 +++++
 rtl/demod_regs_if.sv | 16 +
 rtl/demod_regs_chan.sv | 143 ++++++++++++++
 rtl/demod_regs_mc.sv | 112 +++++++++++
 4 files changed

// File: rtl/demod_regs_pkg.sv
// demod_regs_pkg: word offsets, field positions and widths for the demod register bank
package demod_regs_pkg;

    localparam logic [2:0] W_CTRL      = 3'd0;
    localparam logic [2:0] W_DACSEL    = 3'd1;
    localparam logic [2:0] W_FALSELOCK = 3'd2;
    localparam logic [2:0] W_STATUS    = 3'd3;
    localparam logic [2:0] W_AMTC      = 3'd4;
    localparam logic [2:0] W_FSKDEV    = 3'd5;
    localparam logic [2:0] W_EVENT     = 3'd6;
    localparam logic [2:0] W_LOSSCNT   = 3'd7;

    localparam int STATUS_W = 5;
    localparam int ST_DEMOD   = 0;
    localparam int ST_BITSYNC = 1;
    localparam int ST_HFO     = 2;
    localparam int ST_AU      = 3;
    localparam int ST_DESP    = 4;

    typedef logic [STATUS_W-1:0] status_t;

    // Events fire on a falling edge except high_freq_offset, which is a rising-edge event
    localparam status_t RISE_EVT = status_t'(1) << ST_HFO;

    localparam int MODE_W = 5;
    localparam int BS_W   = 2;
    localparam int DAC_W  = 4;
    localparam int FL_W   = 16;
    localparam int AMTC_W = 5;
    localparam int CNT_W  = 16;
    localparam int DEV_W  = 16;

    localparam int CTRL_MODE_LSB  = 0;
    localparam int CTRL_SC_BIT    = 14;
    localparam int CTRL_DESP_BIT  = 15;
    localparam int CTRL_BS_LSB    = 16;
    localparam int DAC0_LSB       = 0;
    localparam int DAC1_LSB       = 8;
    localparam int DAC2_LSB       = 16;
    localparam int FL_ALPHA_LSB   = 0;
    localparam int FL_THRESH_LSB  = 16;
    localparam int EVT_STICKY_LSB = 0;
    localparam int EVT_MASK_LSB   = 16;

    // Expand 4 byte enables into a 32-bit bit mask
    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/demod_regs_if.sv
// demod_regs_if: processor bus between host and the demod register bank
interface demod_regs_if #(parameter int ADDR_W = 13) ();

    logic              cs;
    logic              wr;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rd_valid;

    modport master (output cs, wr, rd, addr, be, wdata, input rdata, rd_valid);
    modport slave  (input cs, wr, rd, addr, be, wdata, output rdata, rd_valid);

endinterface

// File: rtl/demod_regs_chan.sv
// demod_regs_chan: one channel's settings, lock-loss events, loss counter and word read mux
module demod_regs_chan
    import demod_regs_pkg::*;
#(
    parameter logic [FL_W-1:0] FL_ALPHA_RST  = '0,
    parameter logic [FL_W-1:0] FL_THRESH_RST = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_we,
    input  logic [2:0]        i_word,
    input  logic [3:0]        i_be,
    input  logic [31:0]       i_wdata,
    input  status_t           i_status,
    input  logic [DEV_W-1:0]  i_pos_dev,
    input  logic [DEV_W-1:0]  i_neg_dev,
    output logic [MODE_W-1:0] o_demod_mode,
    output logic              o_enable_sc_path,
    output logic              o_enable_despreader,
    output logic [BS_W-1:0]   o_bitsync_mode,
    output logic [DAC_W-1:0]  o_dac0_sel,
    output logic [DAC_W-1:0]  o_dac1_sel,
    output logic [DAC_W-1:0]  o_dac2_sel,
    output logic [FL_W-1:0]   o_false_lock_alpha,
    output logic [FL_W-1:0]   o_false_lock_threshold,
    output logic [AMTC_W-1:0] o_am_tc,
    output logic              o_irq_src,
    output logic [31:0]       o_rdata
);

    logic [MODE_W-1:0] r_mode;
    logic              r_sc;
    logic              r_desp;
    logic [BS_W-1:0]   r_bs;
    logic [DAC_W-1:0]  r_dac0, r_dac1, r_dac2;
    logic [FL_W-1:0]   r_alpha, r_thresh;
    logic [AMTC_W-1:0] r_am_tc;
    status_t           r_prev, r_sticky, r_mask;
    logic [CNT_W-1:0]  r_loss;

    logic [31:0] w_bm;
    status_t     w_evt, w_w1c;
    logic        w_clr_cnt;

    assign w_bm      = be_mask(i_be);
    assign w_evt     = (r_prev & ~i_status & ~RISE_EVT) | (~r_prev & i_status & RISE_EVT);
    assign w_w1c     = (i_we && i_word == W_EVENT && i_be[0]) ? i_wdata[EVT_STICKY_LSB +: STATUS_W] : '0;
    assign w_clr_cnt = i_we && i_word == W_LOSSCNT && i_be[0];

    // Byte-enabled writes to the RW settings and interrupt mask
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode   <= '0;
            r_sc     <= 1'b0;
            r_desp   <= 1'b0;
            r_bs     <= '0;
            r_dac0   <= '0;
            r_dac1   <= '0;
            r_dac2   <= '0;
            r_alpha  <= FL_ALPHA_RST;
            r_thresh <= FL_THRESH_RST;
            r_am_tc  <= '0;
            r_mask   <= '0;
        end else if (i_we) begin
            if (i_word == W_CTRL) begin
                if (i_be[0]) r_mode <= i_wdata[CTRL_MODE_LSB +: MODE_W];
                if (i_be[1]) r_sc <= i_wdata[CTRL_SC_BIT];
                if (i_be[1]) r_desp <= i_wdata[CTRL_DESP_BIT];
                if (i_be[2]) r_bs <= i_wdata[CTRL_BS_LSB +: BS_W];
            end
            if (i_word == W_DACSEL) begin
                if (i_be[0]) r_dac0 <= i_wdata[DAC0_LSB +: DAC_W];
                if (i_be[1]) r_dac1 <= i_wdata[DAC1_LSB +: DAC_W];
                if (i_be[2]) r_dac2 <= i_wdata[DAC2_LSB +: DAC_W];
            end
            if (i_word == W_FALSELOCK) begin
                r_alpha  <= (r_alpha & ~w_bm[FL_ALPHA_LSB +: FL_W])
                          | (i_wdata[FL_ALPHA_LSB +: FL_W] & w_bm[FL_ALPHA_LSB +: FL_W]);
                r_thresh <= (r_thresh & ~w_bm[FL_THRESH_LSB +: FL_W])
                          | (i_wdata[FL_THRESH_LSB +: FL_W] & w_bm[FL_THRESH_LSB +: FL_W]);
            end
            if (i_word == W_AMTC && i_be[0]) r_am_tc <= i_wdata[AMTC_W-1:0];
            if (i_word == W_EVENT && i_be[2]) r_mask <= i_wdata[EVT_MASK_LSB +: STATUS_W];
        end
    end

    // Edge detect, sticky events (a new event beats a same-cycle clear) and saturating loss counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev   <= '0;
            r_sticky <= '0;
            r_loss   <= '0;
        end else begin
            r_prev   <= i_status;
            r_sticky <= (r_sticky & ~w_w1c) | w_evt;
            if (w_clr_cnt)
                r_loss <= CNT_W'(w_evt[ST_DEMOD]);
            else if (w_evt[ST_DEMOD] && r_loss != '1)
                r_loss <= r_loss + 1'b1;
        end
    end

    // Word read mux; status and deviation are passed through live
    always_comb begin
        o_rdata = '0;
        case (i_word)
            W_CTRL: begin
                o_rdata[CTRL_MODE_LSB +: MODE_W] = r_mode;
                o_rdata[CTRL_SC_BIT]             = r_sc;
                o_rdata[CTRL_DESP_BIT]           = r_desp;
                o_rdata[CTRL_BS_LSB +: BS_W]     = r_bs;
            end
            W_DACSEL: begin
                o_rdata[DAC0_LSB +: DAC_W] = r_dac0;
                o_rdata[DAC1_LSB +: DAC_W] = r_dac1;
                o_rdata[DAC2_LSB +: DAC_W] = r_dac2;
            end
            W_FALSELOCK: o_rdata = {r_thresh, r_alpha};
            W_STATUS:    o_rdata[STATUS_W-1:0] = i_status;
            W_AMTC:      o_rdata[AMTC_W-1:0] = r_am_tc;
            W_FSKDEV:    o_rdata = {i_neg_dev, i_pos_dev};
            W_EVENT: begin
                o_rdata[EVT_STICKY_LSB +: STATUS_W] = r_sticky;
                o_rdata[EVT_MASK_LSB +: STATUS_W]   = r_mask;
            end
            W_LOSSCNT:   o_rdata[CNT_W-1:0] = r_loss;
            default:     o_rdata = '0;
        endcase
    end

    assign o_demod_mode           = r_mode;
    assign o_enable_sc_path       = r_sc;
    assign o_enable_despreader    = r_desp;
    assign o_bitsync_mode         = r_bs;
    assign o_dac0_sel             = r_dac0;
    assign o_dac1_sel             = r_dac1;
    assign o_dac2_sel             = r_dac2;
    assign o_false_lock_alpha     = r_alpha;
    assign o_false_lock_threshold = r_thresh;
    assign o_am_tc                = r_am_tc;
    assign o_irq_src              = |(r_sticky & r_mask);

endmodule

// File: rtl/demod_regs_mc.sv
// demod_regs_mc: multi-channel demod control/status register bank with lock-loss interrupt
module demod_regs_mc
    import demod_regs_pkg::*;
#(
    parameter int                NUM_CH        = 2,
    parameter int                ADDR_W        = 13,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 13'h0400,
    parameter logic [FL_W-1:0]   FL_ALPHA_RST  = 16'h0000,
    parameter logic [FL_W-1:0]   FL_THRESH_RST = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    demod_regs_if.slave              bus,
    input  logic [NUM_CH-1:0]        i_demod_lock,
    input  logic [NUM_CH-1:0]        i_bitsync_lock,
    input  logic [NUM_CH-1:0]        i_au_bitsync_lock,
    input  logic [NUM_CH-1:0]        i_high_freq_offset,
    input  logic [NUM_CH-1:0]        i_despread_lock,
    input  logic [DEV_W*NUM_CH-1:0]  i_pos_dev,
    input  logic [DEV_W*NUM_CH-1:0]  i_neg_dev,
    output logic [MODE_W*NUM_CH-1:0] o_demod_mode,
    output logic [NUM_CH-1:0]        o_enable_despreader,
    output logic [NUM_CH-1:0]        o_enable_sc_path,
    output logic [BS_W*NUM_CH-1:0]   o_bitsync_mode,
    output logic [DAC_W*NUM_CH-1:0]  o_dac0_sel,
    output logic [DAC_W*NUM_CH-1:0]  o_dac1_sel,
    output logic [DAC_W*NUM_CH-1:0]  o_dac2_sel,
    output logic [FL_W*NUM_CH-1:0]   o_false_lock_alpha,
    output logic [FL_W*NUM_CH-1:0]   o_false_lock_threshold,
    output logic [AMTC_W*NUM_CH-1:0] o_am_tc,
    output logic                     o_irq
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic            w_hit, w_wr, w_rd;
    logic [CH_W-1:0] w_ch;
    logic [2:0]      w_word;
    logic [1:0]      w_unused_addr;
    logic [31:0]     w_ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] w_irq_src;
    logic [31:0]     w_rd_data;
    logic [31:0]     r_rdata;
    logic            r_rd_valid;
    logic            r_irq;

    assign w_hit         = bus.cs && (bus.addr[ADDR_W-1:CH_W+5] == BASE_ADDR[ADDR_W-1:CH_W+5]);
    assign w_wr          = w_hit && bus.wr;
    assign w_rd          = w_hit && bus.rd;
    assign w_ch          = bus.addr[CH_W+4:5];
    assign w_word        = bus.addr[4:2];
    assign w_unused_addr = bus.addr[1:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        status_t w_status;
        assign w_status[ST_DEMOD]   = i_demod_lock[g];
        assign w_status[ST_BITSYNC] = i_bitsync_lock[g];
        assign w_status[ST_HFO]     = i_high_freq_offset[g];
        assign w_status[ST_AU]      = i_au_bitsync_lock[g];
        assign w_status[ST_DESP]    = i_despread_lock[g];

        demod_regs_chan #(
            .FL_ALPHA_RST  (FL_ALPHA_RST),
            .FL_THRESH_RST (FL_THRESH_RST)
        ) u_chan (
            .clk                    (clk),
            .reset_n                (reset_n),
            .i_we                   (w_wr && w_ch == CH_W'(g)),
            .i_word                 (w_word),
            .i_be                   (bus.be),
            .i_wdata                (bus.wdata),
            .i_status               (w_status),
            .i_pos_dev              (i_pos_dev[DEV_W*g +: DEV_W]),
            .i_neg_dev              (i_neg_dev[DEV_W*g +: DEV_W]),
            .o_demod_mode           (o_demod_mode[MODE_W*g +: MODE_W]),
            .o_enable_sc_path       (o_enable_sc_path[g]),
            .o_enable_despreader    (o_enable_despreader[g]),
            .o_bitsync_mode         (o_bitsync_mode[BS_W*g +: BS_W]),
            .o_dac0_sel             (o_dac0_sel[DAC_W*g +: DAC_W]),
            .o_dac1_sel             (o_dac1_sel[DAC_W*g +: DAC_W]),
            .o_dac2_sel             (o_dac2_sel[DAC_W*g +: DAC_W]),
            .o_false_lock_alpha     (o_false_lock_alpha[FL_W*g +: FL_W]),
            .o_false_lock_threshold (o_false_lock_threshold[FL_W*g +: FL_W]),
            .o_am_tc                (o_am_tc[AMTC_W*g +: AMTC_W]),
            .o_irq_src              (w_irq_src[g]),
            .o_rdata                (w_ch_rdata[g])
        );
    end

    // Channel select for reads; channel indices past NUM_CH read as zero
    always_comb begin
        w_rd_data = (int'(w_ch) < NUM_CH) ? w_ch_rdata[w_ch] : '0;
    end

    // Registered read data, read-valid pulse and interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata    <= '0;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) r_rdata <= w_rd_data;
            r_irq      <= |w_irq_src;
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.rd_valid = r_rd_valid;
    assign o_irq        = r_irq;

endmodule
